sparse_dot_accumulator: RTL and testbench

Sums the 16-bit product stream from `zero_detect_mult` over fixed-length vectors of `VEC_LEN` beats and emits one dot-product result per vector. It is the reduction stage directly downstream of the zero-skipping multiplier. When enabled, it also reports how many beats in the vector were zero-skipped. The result is presented with a valid/ready handshake. It exerts backpressure on the multiplier issue logic through `in_ready`.

---
 rtl/sparse_acc_pkg.sv | 20 ++
 rtl/sparse_dot_accumulator.sv | 104 ++++++++++
 tb/tb_sparse_dot_accumulator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sparse_acc_pkg.sv
// Shared definitions for the sparse dot-product accumulator: FSM state
// encoding and counter width helpers.
package sparse_acc_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  // Beat counter only needs to index beats 0..VEC_LEN-1.
  function automatic int beat_cnt_w(input int vec_len);
    return (vec_len < 2) ? 1 : $clog2(vec_len);
  endfunction

  // Skip counter must be able to hold VEC_LEN itself (every beat skipped).
  function automatic int skip_cnt_w(input int vec_len);
    return $clog2(vec_len + 1);
  endfunction

endpackage

// File: rtl/sparse_dot_accumulator.sv
// Reduction stage behind the zero-skipping multiplier: sums VEC_LEN product
// beats into one dot-product result and presents it with valid/ready.
// Optional feature macro: SPARSE_ACC_SKIP_STATS_EN -- when defined, beats
// flagged as skipped are counted and their product is not added; when
// undefined, the skip counter is absent and out_skip_cnt reads 0.
module sparse_dot_accumulator
  import sparse_acc_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PROD_W-1:0]              in_product,
  input  logic                           in_skipped,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               out_sum,
  output logic [skip_cnt_w(VEC_LEN)-1:0] out_skip_cnt
);

  localparam int BEAT_W = beat_cnt_w(VEC_LEN);
  localparam int SKIP_W = skip_cnt_w(VEC_LEN);

  state_t              state_reg;
  logic [BEAT_W-1:0]   beat_cnt_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic                accept;
  logic                last_beat;
  logic                out_hs;
  logic [ACC_W-1:0]    addend;

  // Handshake qualifiers; in_ready is a pure decode of the state register.
  assign in_ready  = (state_reg == ST_ACCUM);
  assign out_valid = (state_reg == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_beat = (beat_cnt_reg == BEAT_W'(VEC_LEN - 1));

  // The accumulator doubles as the result register; it is frozen in DONE.
  assign out_sum = acc_reg;

`ifdef SPARSE_ACC_SKIP_STATS_EN
  logic [SKIP_W-1:0] skip_cnt_reg;

  // Skipped beats contribute zero regardless of the product they carry.
  assign addend = in_skipped ? '0 : {{(ACC_W-PROD_W){1'b0}}, in_product};

  // Count skipped beats of the current vector; cleared when the result leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt_reg <= '0;
    end else if (out_hs) begin
      skip_cnt_reg <= '0;
    end else if (accept && in_skipped) begin
      skip_cnt_reg <= skip_cnt_reg + SKIP_W'(1);
    end
  end

  assign out_skip_cnt = skip_cnt_reg;
`else
  logic unused_skipped;

  assign addend         = {{(ACC_W-PROD_W){1'b0}}, in_product};
  assign out_skip_cnt   = '0;
  assign unused_skipped = in_skipped;
`endif

  // Two-state FSM with the accumulator and beat counter it sequences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_ACCUM;
      beat_cnt_reg <= '0;
      acc_reg      <= '0;
    end else begin
      case (state_reg)
        ST_ACCUM: begin
          if (accept) begin
            acc_reg <= acc_reg + addend;
            if (last_beat) begin
              state_reg <= ST_DONE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg    <= ST_ACCUM;
            beat_cnt_reg <= '0;
            acc_reg      <= '0;
          end
        end
        default: begin
          state_reg <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_dot_accumulator.sv
// Scoreboard bench for sparse_dot_accumulator (VEC_LEN=4). Directed vectors
// from the test plan followed by randomized vectors with random gaps and
// random output backpressure.
module tb_sparse_dot_accumulator;

  localparam int VL     = 4;
  localparam int PW     = 16;
  localparam int AW     = 24;
  localparam int SW     = $clog2(VL + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_product = '0;
  logic          in_skipped = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_sum;
  logic [SW-1:0] out_skip_cnt;

  sparse_dot_accumulator #(.VEC_LEN(VL), .PROD_W(PW), .ACC_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_skipped   (in_skipped),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_skip_cnt (out_skip_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain running totals of the vector in progress.
  longint unsigned mdl_sum   = 0;
  int              mdl_skip  = 0;
  int              mdl_beats = 0;
  bit              mdl_done  = 1'b0;
  longint unsigned exp_sum_q[$];
  int              exp_skip_q[$];
  int              ready_mode = 0;  // 0: high, 1: low, 2: random

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_accept(input int p, input bit s);
`ifdef SPARSE_ACC_SKIP_STATS_EN
    if (s) mdl_skip++;
    else   mdl_sum += p;
`else
    mdl_sum += p;
`endif
    mdl_beats++;
    if (mdl_beats == VL) begin
      exp_sum_q.push_back(mdl_sum % (64'd1 << AW));
      exp_skip_q.push_back(mdl_skip);
      mdl_done  = 1'b1;
      mdl_sum   = 0;
      mdl_skip  = 0;
      mdl_beats = 0;
    end
  endtask

  task automatic mdl_clear_partial();
    mdl_sum   = 0;
    mdl_skip  = 0;
    mdl_beats = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat is taken.
  task automatic send(input int p, input bit s);
    int tries = 0;
    in_valid   = 1'b1;
    in_product = PW'(p);
    in_skipped = s;
    while (!in_ready) begin
      @(posedge clk); #1;
      tries++;
      if (tries > 300) begin
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    mdl_accept(p, s);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: flow-control consistency, hold stability, scoreboard pop.
  initial begin
    bit              held = 1'b0;
    logic [AW-1:0]   held_sum;
    logic [SW-1:0]   held_skip;
    longint unsigned es;
    int              ek;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      chk("out_valid", out_valid, mdl_done);
      chk("in_ready", in_ready, !mdl_done);
      if (held && out_valid) begin
        chk("hold_sum", out_sum, held_sum);
        chk("hold_skip", out_skip_cnt, held_skip);
      end
      held      = out_valid && !out_ready;
      held_sum  = out_sum;
      held_skip = out_skip_cnt;
      if (out_valid && out_ready) begin
        if (exp_sum_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          es = exp_sum_q.pop_front();
          ek = exp_skip_q.pop_front();
          chk("out_sum", out_sum, es);
          chk("out_skip_cnt", out_skip_cnt, ek);
          $display("result: sum=%0d skip=%0d (expected %0d/%0d)", out_sum, out_skip_cnt, es, ek);
        end
        @(posedge clk); #1;
        mdl_done = 1'b0;
      end
    end
  end

  initial begin
    int p;
    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_skip", out_skip_cnt, 0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Skipped zero beats; single-cycle valid with out_ready high
    send(15, 0); send(0, 1); send(0, 1); send(65025, 0);
    idle(3);

    // Largest square products back to back
    repeat (VL) send(65025, 0);
    idle(3);

    // Backpressure: result held, stray in_valid ignored for 3 cycles
    ready_mode = 1;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    in_valid   = 1'b1;
    in_product = 16'd777;
    in_skipped = 1'b0;
    repeat (3) begin
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    ready_mode = 0;
    send(7, 0); send(8, 0); send(9, 0); send(10, 0);
    idle(3);

    // Beats every other cycle
    send(5, 0); idle(1); send(3, 0); idle(1); send(200, 0); idle(1); send(120, 0);
    idle(3);

    // Skipped beat carrying a nonzero product
    send(10, 0); send(99, 1); send(20, 0); send(30, 0);
    idle(3);

    // Asynchronous reset mid-vector, then a clean vector
    send(50, 0); send(60, 0);
    #2;
    rst = 1'b1;
    #1;
    mdl_clear_partial();
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_sum", out_sum, 0);
    chk("arst_skip", out_skip_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    idle(3);

    // Randomized vectors with gaps and random backpressure
    ready_mode = 2;
    for (int v = 0; v < 25; v++) begin
      for (int b = 0; b < VL; b++) begin
        case ($urandom_range(0, 3))
          0:       p = 0;
          1:       p = 65535;
          default: p = int'($urandom_range(0, 65535));
        endcase
        send(p, 1'($urandom_range(0, 3) == 0));
        idle(int'($urandom_range(0, 2)));
      end
    end
    ready_mode = 0;

    // Drain
    for (int i = 0; i < 200 && (exp_sum_q.size() != 0 || mdl_done); i++) idle(1);
    chk("drain_queue_empty", exp_sum_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
